adc_chan_avg: RTL and testbench
===============================

# adc_chan_avg

Per-channel decimating averager downstream of the ADC serial-port wrapper. It consumes single-cycle sample strobes, 16-bit samples and 3-bit channel tags from the wrapper in the `clk` domain. It accumulates 2^AVG_LOG2 samples per channel and emits each channel's arithmetic mean through a small FIFO with a valid/ready handshake. Samples are accepted only while the wrapper reports data mode.

## Interface
- `AVG_LOG2`, default 4: log2 of the samples averaged per channel; legal range 0..8. A value of 0 means pass-through.
- `FIFO_DEPTH`, default 8: result FIFO entries; must be a power of 2, ≥2.
- `clk` in 1: system clock; the only clock.
- `rst_l` in 1: asynchronous, active-low reset.
- `s_valid` in 1: sample strobe (wrapper RD_EN), one-cycle pulse.
- `s_data` in 16: sample, two's complement.
- `s_chan` in 3: channel tag of `s_data`.
- `op_mode` in 1: 1 means the ADC is in data mode (wrapper OP_MODE).
- `m_valid` out 1: result available.
- `m_ready` in 1: consumer accepts the result.
- `m_data` out 16: averaged sample, two's complement.
- `m_chan` out 3: channel of `m_data`.
- `fill` out clog2(FIFO_DEPTH)+1: FIFO occupancy.
- `ovf` out 1: sticky flag, set when a result was dropped.
- `clr_ovf` in 1: synchronous clear of `ovf`.

## Operation
- Per-channel state, 8 channels:
  - accumulator, signed, width 16+AVG_LOG2;
  - sample count, width AVG_LOG2.
- Sample accepted iff `s_valid && op_mode`. Strobes with `op_mode=0` are ignored.
- Accepted sample, count < 2^AVG_LOG2−1: acc[chan] += sign-extended `s_data`; count[chan]++.
- Accepted sample, count = 2^AVG_LOG2−1 (block complete):
  - result = (acc[chan] + sample) arithmetic-shifted right by AVG_LOG2. This truncates toward −∞; no rounding.
  - result is pushed as {chan, result[15:0]};
  - acc[chan] and count[chan] are cleared.
- With AVG_LOG2=0, every accepted sample completes a block and is pushed unchanged.
- Mode exit: a falling edge of `op_mode` clears all accumulators and counts. FIFO contents are kept.
- FIFO:
  - first-word-fall-through; `m_valid` = not empty; `m_data`/`m_chan` show the head.
  - pop on `m_valid && m_ready`.
  - push is accepted if not full, or if full with a pop in the same cycle.
  - otherwise the result is dropped and `ovf` is set.
- `ovf`: set by a drop, cleared by `clr_ovf`. If both occur in the same cycle, set wins.
- Reset values: all accumulators and counts 0; FIFO empty; `m_valid`=0; `m_data`=0; `m_chan`=0; `fill`=0; `ovf`=0.
- Reset mid-operation discards partial sums and FIFO contents immediately (asynchronous).

## Timing
- Stage 1 (cycle N): strobe sampled; accumulator and count updated at the edge ending N.
- Stage 2 (cycle N+1): a completed result is registered as a push request.
- The FIFO write occurs at the edge ending N+1. `m_valid` rises in N+2 if the FIFO was empty.
- Latency from the last sample strobe of a block to `m_valid`: 2 cycles.
- Throughput: one accepted sample per cycle. Back-to-back strobes on the same channel must accumulate correctly, so the Stage-1 read-modify-write must not need forwarding.
- `fill` updates in the same cycle as the push/pop edge. A simultaneous push and pop leaves `fill` unchanged.
- `m_data`/`m_chan` stay stable while `m_valid && !m_ready`.
- `op_mode` falling edge:
  - detected by a 1-cycle delayed copy;
  - the clear takes effect at the following edge;
  - a sample accepted in the same cycle as the detected fall is discarded;
  - a completed result already in Stage 2 is still pushed.

## Structure
- Shared package `adc_pkg`:
  - `ADC_W=16`, `CHAN_W=3`, `N_CHAN=8`;
  - the packed result-word layout {chan, data}.
- Sub-module `sync_fifo`:
  - parameters WIDTH and DEPTH;
  - FWFT; exposes `full`, `empty`, `count`;
  - same `clk`/`rst_l`.
- The averager holds the accumulator/count arrays, the Stage-2 push register, edge detect and `ovf`.

## Test plan
- AVG_LOG2=2, `op_mode`=1, `m_ready`=1, channel 3 fed 0x0001, 0x0002, 0x0003, 0x0006: one result {3, 0x0003} 2 cycles after the 4th strobe; `fill` returns to 0.
- Negative values, AVG_LOG2=1, channel 0 fed 0xFFFF, 0xFFFE: result 0xFFFE (−1.5 truncated toward −∞ gives −2).
- Interleaved channels 0..7, each fed 2^AVG_LOG2 samples of value ch*0x100, back-to-back strobes every cycle: 8 results in completion order with m_data = ch*0x100.
- `m_ready`=0, AVG_LOG2=0, FIFO_DEPTH=8, 9 strobes: `fill`=8, 9th result dropped, `ovf`=1. `clr_ovf` clears `ovf`. Raising `m_ready` drains exactly 8 entries in order.
- Full FIFO plus push and pop in the same cycle: push accepted, `fill` stays 8, `ovf` stays 0.
- Strobes with `op_mode`=0 give no accumulation. An `op_mode` fall after 3 of 4 samples, then re-entry, makes the next 4 samples form a fresh block. `rst_l` asserted mid-block empties everything, and all outputs read their reset values.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared widths and the packed result word {chan, data} used between the
// averager and its result FIFO.
package adc_pkg;
    localparam int ADC_W  = 16;
    localparam int CHAN_W = 3;
    localparam int N_CHAN = 8;

    typedef struct packed {
        logic [CHAN_W-1:0] chan;
        logic [ADC_W-1:0]  data;
    } result_t;

    localparam int RESULT_W = $bits(result_t);
endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO. A write into a full FIFO is
// accepted only when a read retires the head in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_l,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, rptr_q;
    logic [PW:0]      count_q, count_d;
    logic             do_rd, do_wr;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (PW+1)'(DEPTH));
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign count   = count_q;
    // Empty head reads as zero so the output port has a defined reset value.
    assign rd_data = empty ? '0 : mem_q[rptr_q];

    always_comb begin
        count_d = count_q;
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wptr_q] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_wr) wptr_q <= wptr_q + 1'b1;
            if (do_rd) rptr_q <= rptr_q + 1'b1;
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/adc_chan_avg.sv
// Per-channel decimating averager: sums 2^AVG_LOG2 samples per channel and
// queues the floor-mean of each block into a result FIFO.
module adc_chan_avg
    import adc_pkg::*;
#(
    parameter int AVG_LOG2   = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst_l,
    input  logic                        s_valid,
    input  logic [ADC_W-1:0]            s_data,
    input  logic [CHAN_W-1:0]           s_chan,
    input  logic                        op_mode,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [ADC_W-1:0]            m_data,
    output logic [CHAN_W-1:0]           m_chan,
    output logic [$clog2(FIFO_DEPTH):0] fill,
    output logic                        ovf,
    input  logic                        clr_ovf
);
    localparam int ACC_W = ADC_W + AVG_LOG2;
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

    logic signed [ACC_W-1:0] acc_q [N_CHAN];
    logic signed [ACC_W-1:0] acc_d [N_CHAN];
    logic [CNT_W-1:0]        cnt_q [N_CHAN];
    logic [CNT_W-1:0]        cnt_d [N_CHAN];
    logic                    mode_q;
    logic                    push_q, push_d;
    result_t                 push_word_q, push_word_d;
    logic                    ovf_q, ovf_d;

    logic                    accept, mode_fall, blk_done;
    logic signed [ACC_W-1:0] samp_ext, sum;
    logic [ADC_W-1:0]        mean;
    result_t                 head;
    logic                    fifo_full, fifo_empty, pop, drop;

    always_comb begin
        samp_ext  = ACC_W'(signed'(s_data));
        sum       = acc_q[s_chan] + samp_ext;
        mean      = ADC_W'(sum >>> AVG_LOG2);
        accept    = s_valid && op_mode;
        mode_fall = mode_q && !op_mode;
        blk_done  = accept && !mode_fall && (cnt_q[s_chan] == CNT_LAST);

        acc_d = acc_q;
        cnt_d = cnt_q;
        if (mode_fall) begin
            for (int i = 0; i < N_CHAN; i++) begin
                acc_d[i] = '0;
                cnt_d[i] = '0;
            end
        end else if (accept) begin
            if (blk_done) begin
                acc_d[s_chan] = '0;
                cnt_d[s_chan] = '0;
            end else begin
                acc_d[s_chan] = sum;
                cnt_d[s_chan] = cnt_q[s_chan] + 1'b1;
            end
        end

        push_d           = blk_done;
        push_word_d.chan = s_chan;
        push_word_d.data = mean;

        pop   = m_valid && m_ready;
        drop  = push_q && fifo_full && !pop;
        ovf_d = drop ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            for (int i = 0; i < N_CHAN; i++) begin
                acc_q[i] <= '0;
                cnt_q[i] <= '0;
            end
            mode_q      <= 1'b0;
            push_q      <= 1'b0;
            push_word_q <= '0;
            ovf_q       <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            mode_q      <= op_mode;
            push_q      <= push_d;
            push_word_q <= push_word_d;
            ovf_q       <= ovf_d;
        end
    end

    sync_fifo #(
        .WIDTH (RESULT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_l   (rst_l),
        .wr_en   (push_q),
        .wr_data (push_word_q),
        .rd_en   (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fill)
    );

    assign m_valid = !fifo_empty;
    assign m_data  = head.data;
    assign m_chan  = head.chan;
    assign ovf     = ovf_q;
endmodule

// File: tb/tb_adc_chan_avg.sv
// Three averagers (AVG_LOG2 = 0, 1, 2) share one stimulus stream; a
// sum/count/queue model tracks each one cycle by cycle.
module tb_adc_chan_avg;
    logic        clk = 1'b0;
    logic        rst_l, s_valid, op_mode, m_ready, clr_ovf;
    logic [15:0] s_data;
    logic [2:0]  s_chan;

    logic        m_valid [3];
    logic [15:0] m_data  [3];
    logic [2:0]  m_chan  [3];
    logic [3:0]  fill    [3];
    logic        ovf     [3];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    adc_chan_avg #(.AVG_LOG2(0), .FIFO_DEPTH(8)) u_dut0 (
        .clk(clk), .rst_l(rst_l), .s_valid(s_valid), .s_data(s_data), .s_chan(s_chan),
        .op_mode(op_mode), .m_valid(m_valid[0]), .m_ready(m_ready), .m_data(m_data[0]),
        .m_chan(m_chan[0]), .fill(fill[0]), .ovf(ovf[0]), .clr_ovf(clr_ovf));
    adc_chan_avg #(.AVG_LOG2(1), .FIFO_DEPTH(8)) u_dut1 (
        .clk(clk), .rst_l(rst_l), .s_valid(s_valid), .s_data(s_data), .s_chan(s_chan),
        .op_mode(op_mode), .m_valid(m_valid[1]), .m_ready(m_ready), .m_data(m_data[1]),
        .m_chan(m_chan[1]), .fill(fill[1]), .ovf(ovf[1]), .clr_ovf(clr_ovf));
    adc_chan_avg #(.AVG_LOG2(2), .FIFO_DEPTH(8)) u_dut2 (
        .clk(clk), .rst_l(rst_l), .s_valid(s_valid), .s_data(s_data), .s_chan(s_chan),
        .op_mode(op_mode), .m_valid(m_valid[2]), .m_ready(m_ready), .m_data(m_data[2]),
        .m_chan(m_chan[2]), .fill(fill[2]), .ovf(ovf[2]), .clr_ovf(clr_ovf));

    // ---------------- reference model (instance k averages 2^k samples) ----
    int          msum  [3][8];
    int          mcnt  [3][8];
    logic [18:0] mfifo [3][$];
    bit          mpend [3];
    logic [18:0] mpword[3];
    bit          movf  [3];
    bit          mprev;

    function automatic int floor_div(int s, int n);
        if (s >= 0) return s / n;
        return -((-s + n - 1) / n);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < 8; c++) begin
                msum[k][c] = 0;
                mcnt[k][c] = 0;
            end
            mfifo[k].delete();
            mpend[k]  = 1'b0;
            mpword[k] = '0;
            movf[k]   = 1'b0;
        end
        mprev = 1'b0;
    endtask

    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            bit          pop, push, drop, npend;
            logic [18:0] nw;
            int          nn;
            nn   = 1 << k;
            pop  = (mfifo[k].size() > 0) && m_ready;
            push = 1'b0;
            drop = 1'b0;
            if (mpend[k]) begin
                if (mfifo[k].size() < 8 || pop) push = 1'b1;
                else                             drop = 1'b1;
            end
            if (pop)  void'(mfifo[k].pop_front());
            if (push) mfifo[k].push_back(mpword[k]);
            if (drop)         movf[k] = 1'b1;
            else if (clr_ovf) movf[k] = 1'b0;
            npend = 1'b0;
            nw    = '0;
            if (mprev && !op_mode) begin
                for (int c = 0; c < 8; c++) begin
                    msum[k][c] = 0;
                    mcnt[k][c] = 0;
                end
            end else if (s_valid && op_mode) begin
                msum[k][s_chan] += int'($signed(s_data));
                mcnt[k][s_chan] += 1;
                if (mcnt[k][s_chan] == nn) begin
                    npend = 1'b1;
                    nw    = {s_chan, 16'(floor_div(msum[k][s_chan], nn))};
                    msum[k][s_chan] = 0;
                    mcnt[k][s_chan] = 0;
                end
            end
            mpend[k]  = npend;
            mpword[k] = nw;
        end
        mprev = op_mode;
    endtask

    task automatic check_model(string tag);
        for (int k = 0; k < 3; k++) begin
            logic [18:0] h;
            logic [24:0] exp_v, got_v;
            h     = (mfifo[k].size() > 0) ? mfifo[k][0] : 19'd0;
            exp_v = {mfifo[k].size() > 0, h[18:16], h[15:0], 4'(mfifo[k].size()), movf[k]};
            got_v = {m_valid[k], m_chan[k], m_data[k], fill[k], ovf[k]};
            n_vec++;
            if (got_v !== exp_v) begin
                n_err++;
                $display("FAIL %s L=%0d t=%0t: got v=%0b ch=%0d d=%h fill=%0d ovf=%0b, need v=%0b ch=%0d d=%h fill=%0d ovf=%0b",
                         tag, k, $time, got_v[24], got_v[23:21], got_v[20:5], got_v[4:1], got_v[0],
                         exp_v[24], exp_v[23:21], exp_v[20:5], exp_v[4:1], exp_v[0]);
            end
        end
    endtask

    task automatic chk_const(int k, bit v, logic [15:0] d, logic [2:0] ch, logic [3:0] f, bit o,
                             int id, string tag);
        logic [24:0] exp_v, got_v;
        exp_v = {v, ch, d, f, o};
        got_v = {m_valid[k], m_chan[k], m_data[k], fill[k], ovf[k]};
        n_vec++;
        if (got_v !== exp_v) begin
            n_err++;
            $display("FAIL %s[%0d] L=%0d: got v=%0b ch=%0d d=%h fill=%0d ovf=%0b, need v=%0b ch=%0d d=%h fill=%0d ovf=%0b",
                     tag, id, k, got_v[24], got_v[23:21], got_v[20:5], got_v[4:1], got_v[0],
                     v, ch, d, f, o);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_model("model");
    endtask

    // Reset is asserted between edges and the outputs are checked before any
    // clock arrives, so the clear must be asynchronous.
    task automatic do_reset();
        s_valid = 1'b0;
        clr_ovf = 1'b0;
        rst_l   = 1'b0;
        #2;
        model_reset();
        for (int k = 0; k < 3; k++) chk_const(k, 1'b0, 16'h0, 3'd0, 4'd0, 1'b0, -1, "reset");
        @(posedge clk);
        #1;
        rst_l = 1'b1;
    endtask

    // ---------------- directed vector table --------------------------------
    typedef struct packed {
        bit          rst;
        bit [1:0]    inst;
        bit          sv;
        logic [15:0] d;
        logic [2:0]  ch;
        bit          op, rdy, clr;
        bit          ev;
        logic [15:0] ed;
        logic [2:0]  ec;
        logic [3:0]  ef;
        bit          eo;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit rst, int inst, bit sv, int d, int ch, bit op, bit rdy, bit clr,
                                bit ev, int ed, int ec, int ef, bit eo);
        vec_t v;
        v.rst = rst;   v.inst = 2'(inst); v.sv = sv;   v.d = 16'(d); v.ch = 3'(ch);
        v.op = op;     v.rdy = rdy;       v.clr = clr;
        v.ev = ev;     v.ed = 16'(ed);    v.ec = 3'(ec); v.ef = 4'(ef); v.eo = eo;
        return v;
    endfunction

    initial begin
        logic [18:0] got[$];
        rst_l = 1'b0; s_valid = 1'b0; s_data = '0; s_chan = '0;
        op_mode = 1'b1; m_ready = 1'b1; clr_ovf = 1'b0;

        // 4-sample mean on channel 3: (1+2+3+6)/4 = 3
        tbl.push_back(mk(1, 2, 1, 1, 3, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 2, 1, 2, 3, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 2, 1, 3, 3, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 2, 1, 6, 3, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 2, 0, 0, 0, 1, 1, 0, 1, 3, 3, 1, 0));
        tbl.push_back(mk(0, 2, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        // -1.5 floors to -2
        tbl.push_back(mk(1, 1, 1, 'hFFFF, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 'hFFFE, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 1, 0, 1, 'hFFFE, 0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        // Overflow: 9 results into an 8-deep FIFO, drop sets ovf over clr_ovf
        for (int k = 0; k < 9; k++)
            tbl.push_back(mk(k == 0, 0, 1, 'h100 + k, k & 7, 1, 0, 0,
                             k > 0, (k > 0) ? 'h100 : 0, 0, k, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 1, 'h100, 0, 8, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 1, 'h100, 0, 8, 0));
        for (int j = 0; j < 8; j++)
            tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, j < 7, (j < 7) ? 'h101 + j : 0,
                             (j < 7) ? ((j + 1) & 7) : 0, 7 - j, 0));
        // Full FIFO with push and pop in one cycle
        for (int k = 0; k < 8; k++)
            tbl.push_back(mk(k == 0, 0, 1, 'h200 + k, k, 1, 0, 0,
                             k > 0, (k > 0) ? 'h200 : 0, 0, k, 0));
        tbl.push_back(mk(0, 0, 1, 'h208, 0, 1, 0, 0, 1, 'h200, 0, 8, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 1, 'h201, 1, 8, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 'h201, 1, 8, 0));
        // op_mode=0 strobes ignored; fall after 3 of 4 samples restarts the block
        for (int k = 0; k < 4; k++) tbl.push_back(mk(k == 0, 2, 1, 'h100, 5, 0, 1, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 3; k++) tbl.push_back(mk(0, 2, 1, 4, 5, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 2, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 4; k++) tbl.push_back(mk(0, 2, 1, 8, 5, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 2, 0, 0, 0, 1, 1, 0, 1, 8, 5, 1, 0));
        tbl.push_back(mk(0, 2, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));

        foreach (tbl[i]) begin
            if (tbl[i].rst) begin
                op_mode = tbl[i].op;
                m_ready = tbl[i].rdy;
                do_reset();
            end
            s_valid = tbl[i].sv;  s_data  = tbl[i].d;   s_chan  = tbl[i].ch;
            op_mode = tbl[i].op;  m_ready = tbl[i].rdy; clr_ovf = tbl[i].clr;
            step();
            chk_const(int'(tbl[i].inst), tbl[i].ev, tbl[i].ed, tbl[i].ec, tbl[i].ef, tbl[i].eo, i, "vec");
        end

        // Interleaved channels, back-to-back strobes, 4 samples each
        op_mode = 1'b1; m_ready = 1'b1;
        do_reset();
        for (int rep = 0; rep < 4; rep++) begin
            for (int ch = 0; ch < 8; ch++) begin
                s_valid = 1'b1; s_data = 16'(ch * 'h100); s_chan = 3'(ch);
                step();
                if (m_valid[2]) got.push_back({m_chan[2], m_data[2]});
            end
        end
        s_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (m_valid[2]) got.push_back({m_chan[2], m_data[2]});
        end
        n_vec++;
        if (got.size() != 8) begin
            n_err++;
            $display("FAIL interleave_count: got %0d results, need 8", got.size());
        end
        for (int i = 0; i < 8; i++) begin
            logic [18:0] e;
            e = {3'(i), 16'(i * 'h100)};
            n_vec++;
            if (i >= got.size() || got[i] !== e) begin
                n_err++;
                $display("FAIL interleave[%0d]: got %h, need %h", i,
                         (i < got.size()) ? got[i] : 19'h7FFFF, e);
            end
        end

        // Reset in the middle of a block with results queued
        op_mode = 1'b1; m_ready = 1'b0;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            s_valid = 1'b1; s_data = 16'h0010; s_chan = 3'd1;
            step();
        end
        s_valid = 1'b0;
        step();
        chk_const(0, 1'b1, 16'h0010, 3'd1, 4'd3, 1'b0, 0, "pre_reset");
        m_ready = 1'b1;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            s_valid = 1'b1; s_data = 16'h0020; s_chan = 3'd1;
            step();
        end
        s_valid = 1'b0;
        step();
        chk_const(2, 1'b1, 16'h0020, 3'd1, 4'd1, 1'b0, 0, "post_reset_block");

        // Randomised traffic against the model
        op_mode = 1'b1;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i == 2000) do_reset();
            if ($urandom_range(0, 199) == 0) op_mode = ~op_mode;
            s_valid = ($urandom_range(0, 3) != 0);
            s_data  = 16'($urandom);
            s_chan  = ($urandom_range(0, 1) == 0) ? 3'($urandom_range(0, 1)) : 3'($urandom_range(0, 7));
            m_ready = (i < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            clr_ovf = ($urandom_range(0, 49) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1);
    end
endmodule
